// File: rtl/lsu_pkg.sv
`default_nettype none
//==============================================================================
// Module      : lsu_pkg
// Description : Shared size encodings, FSM states and request record for the
//               load/store unit.
// Revision    : 1.0 - initial release
//==============================================================================
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] RD   = 3'd1;
    localparam logic [2:0] CAP  = 3'd2;
    localparam logic [2:0] WR   = 3'd3;
    localparam logic [2:0] RESP = 3'd4;
    localparam logic [2:0] ERR  = 3'd5;

    typedef struct packed {
        logic        write;
        logic [1:0]  size;
        logic        sgn;
        logic [1:0]  offset;
        logic [31:0] wdata;
    } lsu_req_t;

    function automatic logic [31:0] word_base(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
//==============================================================================
// Module      : lsu_lane_align
// Description : Big-endian lane extraction/extension for loads and lane merge
//               for sub-word stores. Purely combinational.
// Revision    : 1.0 - initial release
//==============================================================================
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  offset_i,
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merged_o
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Offset 0 is the most significant byte of the word.
    always_comb begin
        w_byte = word_i[31:24];
        case (offset_i)
            2'd0:    w_byte = word_i[31:24];
            2'd1:    w_byte = word_i[23:16];
            2'd2:    w_byte = word_i[15:8];
            default: w_byte = word_i[7:0];
        endcase
        w_half = offset_i[1] ? word_i[15:0] : word_i[31:16];
    end

    always_comb begin
        load_o = word_i;
        case (size_i)
            SZ_BYTE: load_o = {{24{signed_i & w_byte[7]}}, w_byte};
            SZ_HALF: load_o = {{16{signed_i & w_half[15]}}, w_half};
            default: load_o = word_i;
        endcase
    end

    always_comb begin
        merged_o = word_i;
        case (size_i)
            SZ_BYTE: begin
                case (offset_i)
                    2'd0:    merged_o[31:24] = wdata_i[7:0];
                    2'd1:    merged_o[23:16] = wdata_i[7:0];
                    2'd2:    merged_o[15:8]  = wdata_i[7:0];
                    default: merged_o[7:0]   = wdata_i[7:0];
                endcase
            end
            SZ_HALF: begin
                if (offset_i[1]) merged_o[15:0]  = wdata_i[15:0];
                else             merged_o[31:16] = wdata_i[15:0];
            end
            default: merged_o = wdata_i;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
//==============================================================================
// Module      : load_store_unit
// Description : MEM-stage load/store sequencer in front of a word-addressed
//               big-endian memory; sub-word stores use read-modify-write.
// Revision    : 1.0 - initial release
//==============================================================================
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_LIMIT = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        busy,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata
);

    logic [2:0]  state_q, state_d;
    lsu_req_t    req_q;
    logic [31:0] mem_addr_q, mem_wdata_q, rdata_q;
    logic        mem_read_q, mem_write_q, rsp_valid_q, rsp_err_q;

    logic        w_req_ok;
    logic [32:0] w_last_byte;
    logic [31:0] w_load, w_merged;

    // 33-bit sum so a base near the top of the address space cannot wrap.
    assign w_last_byte = {1'b0, word_base(req_addr)} + 33'd3;

    always_comb begin
        w_req_ok = (w_last_byte <= 33'(MEM_LIMIT));
        case (req_size)
            SZ_BYTE: ;
            SZ_HALF: if (req_addr[0])         w_req_ok = 1'b0;
            SZ_WORD: if (req_addr[1:0] != 0)  w_req_ok = 1'b0;
            default: w_req_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (!w_req_ok)                              state_d = ERR;
                    else if (req_write && req_size == SZ_WORD)  state_d = WR;
                    else                                        state_d = RD;
                end
            end
            RD:      state_d = CAP;
            CAP:     state_d = req_q.write ? WR : RESP;
            WR:      state_d = RESP;
            RESP:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    lsu_lane_align u_align (
        .word_i   (mem_rdata),
        .offset_i (req_q.offset),
        .size_i   (req_q.size),
        .signed_i (req_q.sgn),
        .wdata_i  (req_q.wdata),
        .load_o   (w_load),
        .merged_o (w_merged)
    );

    // Strobes and response flags are registered from the next state so they
    // line up exactly with the state they belong to.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            req_q       <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_read_q  <= (state_d == RD);
            mem_write_q <= (state_d == WR);
            rsp_valid_q <= (state_d == RESP) || (state_d == ERR);
            rsp_err_q   <= (state_d == ERR);
            if (state_q == IDLE && req_valid) begin
                req_q <= '{write: req_write, size: req_size, sgn: req_signed,
                           offset: req_addr[1:0], wdata: req_wdata};
                mem_addr_q <= word_base(req_addr);
                if (req_write && req_size == SZ_WORD) mem_wdata_q <= req_wdata;
            end
            if (state_q == CAP) begin
                if (req_q.write) mem_wdata_q <= w_merged;
                else             rdata_q     <= w_load;
            end
        end
    end

    assign busy      = (state_q != IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = (rsp_valid_q && req_q.write) ? 32'h0 : rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;

endmodule
`default_nettype wire
